// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the multi-cycle shift sequencer.
// Master issues start/op/shamt/data_in; slave returns busy/done/result.
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, shamt, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, op, shamt, data_in,
    output busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter: STEP bits per cycle, IDLE/SHIFT/DONE FSM.
// Define SHIFT_SEQ_ROTATE_EN to make op=11 rotate left (else it is SLL).
module shift_sequencer #(
  parameter int STEP = 2
) (
  input logic               clk,
  input logic               reset_n,
  shift_sequencer_if.slave  bus
);

  localparam logic [4:0] STEP_W = 5'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] work_q;
  logic [31:0] result_q;
  logic [1:0]  op_q;
  logic [4:0]  rem_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  n_d;
  logic [4:0]  rem_d;
  logic [31:0] work_d;

  // Final step may be shorter than STEP when remaining is odd.
  always_comb begin
    n_d   = (rem_q > STEP_W) ? STEP_W : rem_q;
    rem_d = rem_q - n_d;
    unique case (1'b1)
      op_q == 2'b01: work_d = work_q >> n_d;
      op_q == 2'b10: work_d = $signed(work_q) >>> n_d;
`ifdef SHIFT_SEQ_ROTATE_EN
      op_q == 2'b11: work_d = (work_q << n_d)
                            | (work_q >> (6'd32 - {1'b0, n_d}));
`endif
      default:       work_d = work_q << n_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            work_q <= bus.data_in;
            op_q   <= bus.op;
            rem_q  <= bus.shamt;
            if (bus.shamt == 5'd0) begin
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= bus.data_in;
            end else begin
              state_q <= SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == 5'd0) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= work_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter STEP, default 2, bits shifted per SHIFT cycle; legal values 1 or 2.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE or DONE.
REQ-005 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 see REQ-024/025.
REQ-006 shamt  input  5  shift amount 0..31, sampled with start.
REQ-007 data_in  input  32  operand, sampled with start.
REQ-008 busy  output  1  high while in SHIFT state.
REQ-009 done  output  1  one-cycle completion pulse, high only in DONE state.
REQ-010 result  output  32  shifted value; valid when done is high, held until next accepted start.

Function
REQ-011 FSM states IDLE, SHIFT, DONE SHALL be the only states; encoding free.
REQ-012 IDLE/DONE with start=1 at edge E0: latch data_in into work register, op, remaining=shamt; go to SHIFT if shamt!=0, else DONE.
REQ-013 DONE with start=0 SHALL return to IDLE on next edge; DONE with start=1 SHALL behave as REQ-012 (back-to-back accepted).
REQ-014 SHIFT: each edge shifts work register by n=min(STEP,remaining) and decrements remaining by n; when remaining reaches 0, go to DONE.
REQ-015 Latency: done SHALL be high in the cycle following edge E(k), k=ceil(shamt/STEP); shamt=0 gives done after E0.
REQ-016 SLL fills zeros at bit 0; SRL fills zeros at bit 31; SRA replicates latched bit 31.
REQ-017 start while in SHIFT SHALL be ignored; inputs not re-sampled; operation continues unchanged.
REQ-018 Inputs SHALL only be used at accepting edge; input changes during SHIFT SHALL NOT affect result.
REQ-019 result SHALL update only on entry to DONE and otherwise hold its value, including through IDLE.
REQ-020 busy and done SHALL never be high simultaneously.

Reset
REQ-021 reset_n low SHALL immediately force IDLE, busy=0, done=0, result=0, remaining=0, work register=0.
REQ-022 Reset asserted mid-SHIFT SHALL abort operation; no done pulse SHALL follow release.
REQ-023 After reset_n release, first rising edge with start=1 SHALL be accepted per REQ-012.

Configuration
REQ-024 Macro SHIFT_SEQ_ROTATE_EN defined: op=11 SHALL rotate left (bit 31 wraps to bit 0), same latency as REQ-015.
REQ-025 Macro undefined: op=11 SHALL execute as SLL; no rotate logic SHALL be synthesised.

Verification
REQ-026 Reset, then start, op=00, shamt=2, data_in=0x0000_0001, STEP=2 -> done after E1, result=0x0000_0004, busy high for 1 cycle.
REQ-027 op=10, shamt=5, data_in=0x8000_0000, STEP=2 -> done after E3, result=0xFC00_0000; op=01 same operands -> result=0x0400_0000.
REQ-028 op=00, shamt=0, data_in=0xDEAD_BEEF -> done after E0, busy never high, result=0xDEAD_BEEF.
REQ-029 op=01, shamt=31, data_in=0xFFFF_FFFF, STEP=1; pulse start and change data_in to 0 mid-SHIFT -> done after E31, result=0x0000_0001.
REQ-030 start op=00 shamt=8; assert reset_n low after E2 for 1 cycle -> busy=0, done=0, result=0 at once; no done pulse afterwards.
REQ-031 With SHIFT_SEQ_ROTATE_EN: op=11, shamt=4, data_in=0x1234_5678 -> result=0x2345_6781; without macro -> result=0x2345_6780.
